snitch_axi_req_arbiter: RTL
===========================

# snitch_axi_req_arbiter

Round-robin arbiter sharing one Snitch AXI adapter request/response port among `NumReq` requesters (core data ports, accelerator, PTW). It sits between the requesters and the adapter's `slv_q*`/`slv_p*` interface. It forwards one request per cycle and holds the grant until that request is accepted. Reads are in-order and single-ID, so it records the owner of every outstanding read and routes read responses, including bursts, back to the owner.

## Interface
Parameters:
- `NumReq`, 2, number of requesters (≥2)
- `MaxReads`, 4, outstanding read transactions tracked (power of two, ≥1)
- `addr_t`, logic, request address type
- `data_t`, logic, data type
- `strb_t`, logic, byte strobe type

Ports (`IdxW = $clog2(NumReq)`):
- `clk_i`  in  1  clock, all logic rising-edge
- `rst_i`  in  1  reset; asynchronous, active-high
- `req_qaddr_i` / `req_qwrite_i` / `req_qamo_i` / `req_qdata_i` / `req_qsize_i` / `req_qstrb_i` / `req_qrlen_i`  in  [NumReq] × addr_t / 1 / 4 / data_t / 3 / strb_t / 8  per-requester request fields
- `req_qvalid_i`  in  NumReq  request valid
- `req_qready_o`  out  NumReq  request accepted
- `req_pdata_o`  out  [NumReq] × data_t  response data, broadcast to all requesters
- `req_perror_o`, `req_plast_o`  out  NumReq  response error and last beat, per requester
- `req_pvalid_o`  out  NumReq  response valid, owner only
- `req_pready_i`  in  NumReq  response ready
- `mst_q*_o`  out  request fields to the adapter, same widths as the `req_q*` fields
- `mst_qvalid_o`  out  1;  `mst_qready_i`  in  1
- `mst_pdata_i`  in  data_t;  `mst_perror_i`, `mst_plast_i`, `mst_pvalid_i`  in  1;  `mst_pready_o`  out  1

## Operation
- Arbitration:
  - Round-robin pointer `rr_q` (IdxW bits).
  - Winner is the first `req_qvalid_i` at index ≥ `rr_q`, wrapping modulo `NumReq`.
  - The selected request's fields are muxed onto `mst_q*_o`. `mst_qvalid_o = winner exists && !blocked`.
- Blocking: a read is blocked while the owner FIFO is full. A blocked read loses arbitration and the search continues to the next valid requester. Writes are never blocked.
- Grant lock:
  - If `mst_qvalid_o && !mst_qready_i`, set `lock_q` and store the winner in `lock_idx_q`.
  - While `lock_q` is set, the winner is forced to `lock_idx_q`.
  - `lock_q` clears on the handshake.
  - A requester must not drop `qvalid` while locked. This is checked by an assertion.
- `req_qready_o[i] = mst_qready_i && mst_qvalid_o && (winner == i)`.
- On handshake: `rr_q <= winner + 1`, wrapping to 0 after `NumReq-1`.
- Owner FIFO:
  - Depth `MaxReads`, entries IdxW bits.
  - Push the winner index on a read handshake (`!qwrite`). AMO requests count as writes here, because the adapter returns no read-channel data for them.
  - Pop on `mst_pvalid_i && mst_pready_o && mst_plast_i`. Non-last beats keep the head.
- Response routing:
  - `req_pvalid_o[head] = mst_pvalid_i`; all other bits are 0.
  - `mst_pready_o = req_pready_i[head]`.
  - `perror`/`plast` are routed to head only.
- Response with FIFO empty: `mst_pready_o=0`, all `req_pvalid_o=0`. A protocol assertion fires.
- Simultaneous push and pop when full: allowed only via the pop-first rule. The full flag uses the pre-pop count, so a read is blocked that cycle.

## Timing
- Request path is combinational: `req_qvalid_i` to `mst_qvalid_o` in 0 cycles; `mst_qready_i` to `req_qready_o` in 0 cycles.
- Response path is combinational from FIFO head: 0 cycles.
- State (`rr_q`, `lock_q`, `lock_idx_q`, FIFO pointers and count) updates on the clock edge after a handshake.
- Reset values:
  - `rr_q=0`, `lock_q=0`, FIFO empty.
  - All `req_qready_o`, `req_pvalid_o`, `mst_qvalid_o`, `mst_pready_o` read 0 while `rst_i` is high.
- Reset mid-operation clears all tracking. Responses still in flight to a requester are then dropped (`mst_pready_o=0`), and the environment must reset the adapter concurrently.
- No combinational path from `mst_pvalid_i` to `mst_qvalid_o`.

## Configuration
- `SNITCH_AXI_ARB_ERRCNT_EN`: when defined, adds output port `err_cnt_o` (16 bits).
  - Reset value 0.
  - Increments on every response handshake beat with `mst_perror_i=1`.
  - Saturates at 0xFFFF.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

## Test plan
- Two requesters read simultaneously at reset (`rr_q=0`) with `mst_qready_i=1` → req0 granted cycle 0, req1 granted cycle 1. Responses 0xA, then 0xB route to req0, then req1.
- req1 asserts a read while `mst_qready_i=0` for 3 cycles, and req0 becomes valid in cycle 1 → grant stays on req1 until its handshake in cycle 3, then req0 is granted.
- `MaxReads=4`: issue 4 reads with no responses → 5th read has `req_qready_o=0` while a concurrent write from the other requester is accepted. One response with `plast=1` then unblocks the read.
- Burst read with `qrlen=3` from req1 → 4 beats delivered to req1. The FIFO pops only on beat 4. A req0 read response follows correctly.
- Backpressure: `req_pready_i[0]=0` for 2 cycles during a response → `mst_pready_o=0` and no pop.
- With `SNITCH_AXI_ARB_ERRCNT_EN` defined: 3 responses with `perror=1` → `err_cnt_o=3`. Reset mid-test → `err_cnt_o=0` and FIFO empty.

Source files
------------

// File: rtl/snitch_axi_req_arbiter.sv
// Round-robin arbiter sharing one Snitch AXI adapter port among NumReq requesters, routing in-order read responses back to their owners.
// Optional: define SNITCH_AXI_ARB_ERRCNT_EN to add a saturating 16-bit error-response counter on err_cnt_o.
module snitch_axi_req_arbiter #(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned MaxReads = 4,
    parameter type         addr_t   = logic,
    parameter type         data_t   = logic,
    parameter type         strb_t   = logic
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  addr_t             req_qaddr_i  [NumReq],
    input  logic [NumReq-1:0] req_qwrite_i,
    input  logic [3:0]        req_qamo_i   [NumReq],
    input  data_t             req_qdata_i  [NumReq],
    input  logic [2:0]        req_qsize_i  [NumReq],
    input  strb_t             req_qstrb_i  [NumReq],
    input  logic [7:0]        req_qrlen_i  [NumReq],
    input  logic [NumReq-1:0] req_qvalid_i,
    output logic [NumReq-1:0] req_qready_o,
    output data_t             req_pdata_o  [NumReq],
    output logic [NumReq-1:0] req_perror_o,
    output logic [NumReq-1:0] req_plast_o,
    output logic [NumReq-1:0] req_pvalid_o,
    input  logic [NumReq-1:0] req_pready_i,
    output addr_t             mst_qaddr_o,
    output logic              mst_qwrite_o,
    output logic [3:0]        mst_qamo_o,
    output data_t             mst_qdata_o,
    output logic [2:0]        mst_qsize_o,
    output strb_t             mst_qstrb_o,
    output logic [7:0]        mst_qrlen_o,
    output logic              mst_qvalid_o,
    input  logic              mst_qready_i,
    input  data_t             mst_pdata_i,
    input  logic              mst_perror_i,
    input  logic              mst_plast_i,
    input  logic              mst_pvalid_i,
    output logic              mst_pready_o
`ifdef SNITCH_AXI_ARB_ERRCNT_EN
    ,
    output logic [15:0]       err_cnt_o
`endif
);

    localparam int unsigned IdxW = $clog2(NumReq);
    localparam int unsigned PtrW = (MaxReads > 1) ? $clog2(MaxReads) : 1;
    localparam int unsigned CntW = $clog2(MaxReads + 1);

    logic [IdxW-1:0] rr_q, lock_idx_q, winner, cand, head;
    logic            lock_q, found, blocked, hs, push, pop, full, empty, resp_ok;
    logic [IdxW-1:0] owner_mem [MaxReads];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q;

    // AMOs return no read-channel data, so they are tracked like writes.
    function automatic logic is_read(input logic write, input logic [3:0] amo);
        return !write && (amo == 4'd0);
    endfunction

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(MaxReads - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full  = (cnt_q == CntW'(MaxReads));
    assign empty = (cnt_q == '0);

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        if (lock_q) begin
            found  = req_qvalid_i[lock_idx_q];
            winner = lock_idx_q;
        end else begin
            for (int k = 0; k < int'(NumReq); k++) begin
                cand = IdxW'((int'(rr_q) + k) % int'(NumReq));
                if (!found && req_qvalid_i[cand] &&
                    !(full && is_read(req_qwrite_i[cand], req_qamo_i[cand]))) begin
                    found  = 1'b1;
                    winner = cand;
                end
            end
        end
    end

    // Full flag uses the pre-pop count, so a read is never pushed into a full FIFO.
    assign blocked      = full && is_read(req_qwrite_i[winner], req_qamo_i[winner]);
    assign mst_qvalid_o = found && !blocked && !rst_i;
    assign hs           = mst_qvalid_o && mst_qready_i;
    assign push         = hs && is_read(req_qwrite_i[winner], req_qamo_i[winner]);

    assign mst_qaddr_o  = req_qaddr_i[winner];
    assign mst_qwrite_o = req_qwrite_i[winner];
    assign mst_qamo_o   = req_qamo_i[winner];
    assign mst_qdata_o  = req_qdata_i[winner];
    assign mst_qsize_o  = req_qsize_i[winner];
    assign mst_qstrb_o  = req_qstrb_i[winner];
    assign mst_qrlen_o  = req_qrlen_i[winner];

    always_comb begin
        req_qready_o = '0;
        if (hs) req_qready_o[winner] = 1'b1;
    end

    assign head         = owner_mem[rd_ptr_q];
    assign resp_ok      = !empty && !rst_i;
    assign mst_pready_o = resp_ok && req_pready_i[head];
    assign pop          = mst_pvalid_i && mst_pready_o && mst_plast_i;

    always_comb begin
        req_pvalid_o = '0;
        req_perror_o = '0;
        req_plast_o  = '0;
        for (int i = 0; i < int'(NumReq); i++) req_pdata_o[i] = mst_pdata_i;
        if (resp_ok) begin
            req_pvalid_o[head] = mst_pvalid_i;
            req_perror_o[head] = mst_perror_i;
            req_plast_o[head]  = mst_plast_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else begin
            if (hs) rr_q <= (winner == IdxW'(NumReq - 1)) ? '0 : winner + IdxW'(1);
            if (mst_qvalid_o && !mst_qready_i) begin
                lock_q     <= 1'b1;
                lock_idx_q <= winner;
            end else if (hs) begin
                lock_q <= 1'b0;
            end
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) owner_mem[wr_ptr_q] <= winner;
    end

`ifdef SNITCH_AXI_ARB_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else if (mst_pvalid_i && mst_pready_o && mst_perror_i && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

    lock_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
        lock_q |-> req_qvalid_i[lock_idx_q]);

    resp_owner_a: assert property (@(posedge clk_i) disable iff (rst_i)
        mst_pvalid_i |-> !empty);

endmodule
